// File: rtl/conv_pkg.sv
// Shared constants for the conv_decimator slice: default widths and
// the two-state accumulator FSM encoding.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int MAX_LOG2_DEF   = 4;
  localparam int ACC_WIDTH_DEF  = DATA_WIDTH_DEF + MAX_LOG2_DEF;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

endpackage

// File: rtl/conv_decim_outreg.sv
// One-entry valid/ready holding register with a sticky overflow flag.
// Ports: load_i/data_i (new result), ready_i (sink), clr_ovf_i,
//        valid_o/data_o (held result), overflow_o (result dropped).
module conv_decim_outreg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  input  logic                  clr_ovf_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  overflow_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  accept;

  // The slot can take a new result if empty or being drained now.
  assign accept = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (load_i && accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (load_i) begin
      ovf_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/conv_decimator.sv
// Integrate-and-dump decimator: averages blocks of 2^k samples.
// Ports: valid_in/y_in (stream), decim_log2 (k), flush, clr_ovf,
//        valid_out/ready_out/d_out (result), overflow, busy.
// Macro CONV_DECIM_ROUND_EN selects round-half-up over truncation.
module conv_decimator
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_LOG2   = MAX_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [2:0]            decim_log2,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int AW = DATA_WIDTH + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;

  logic [0:0]            state_q, state_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [AW-1:0]         sext, sum;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_n, blk;
  logic [2:0]            k_q, k_d, kin, kcur;
  logic                  done;
  logic [DATA_WIDTH-1:0] res;

  assign sext  = {{MAX_LOG2{y_in[DATA_WIDTH-1]}}, y_in};
  assign kin   = (decim_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2)
                                             : decim_log2;
  assign blk   = CW'(1) << k_q;
  assign cnt_n = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    kcur    = k_q;
    sum     = acc_q + sext;
    done    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (valid_in) begin
      unique case (state_q)
        IDLE: begin
          k_d  = kin;
          kcur = kin;
          sum  = sext;
          if (kin == 3'd0) begin
            done = 1'b1;
          end else begin
            state_d = ACC;
            acc_d   = sext;
            cnt_d   = CW'(1);
          end
        end
        default: begin
          if (cnt_n == blk) begin
            done    = 1'b1;
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_n;
          end
        end
      endcase
    end
  end

`ifdef CONV_DECIM_ROUND_EN
  logic [AW:0] bias, rsum;
  always_comb begin
    bias = '0;
    if (kcur != 3'd0) bias = (AW+1)'(1) << (kcur - 3'd1);
    // One guard bit keeps the rounding add from wrapping.
    rsum = {sum[AW-1], sum} + bias;
    res  = DATA_WIDTH'($signed(rsum) >>> kcur);
  end
`else
  always_comb begin
    res = DATA_WIDTH'($signed(sum) >>> kcur);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
    end
  end

  assign busy = (state_q == ACC);

  conv_decim_outreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (done),
    .data_i    (res),
    .ready_i   (ready_out),
    .clr_ovf_i (clr_ovf),
    .valid_o   (valid_out),
    .data_o    (d_out),
    .overflow_o(overflow)
  );

endmodule

// File: tb/tb_conv_decimator.sv
// Directed self-checking bench for conv_decimator.
// Expected averages follow CONV_DECIM_ROUND_EN when defined.
module tb_conv_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] y_in = '0;
  logic [2:0]  decim_log2 = '0;
  logic        flush = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic [15:0] d_out;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad = 0;

  conv_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .y_in      (y_in),
    .decim_log2(decim_log2),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .d_out     (d_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    valid_in = 1'b1;
    y_in = v;
    step();
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (valid_out !== 1'b0) begin
      $display("FAIL rst_valid got=%b want=0", valid_out); bad++;
    end
    total++;
    if (d_out !== 16'h0000) begin
      $display("FAIL rst_dout got=%h want=0000", d_out); bad++;
    end
    total++;
    if ({overflow, busy} !== 2'b00) begin
      $display("FAIL rst_flags got=%b want=00", {overflow, busy}); bad++;
    end
    rst = 1'b0;
  endtask

  task automatic test_average();
    logic [15:0] exp;
`ifdef CONV_DECIM_ROUND_EN
    exp = 16'd3;
`else
    exp = 16'd2;
`endif
    decim_log2 = 3'd2;
    ready_out = 1'b1;
    send(16'd1);
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL avg_busy got=%b want=1", busy); bad++;
    end
    send(16'd2);
    send(16'd3);
    total++;
    if (valid_out !== 1'b0) begin
      $display("FAIL avg_early got=%b want=0", valid_out); bad++;
    end
    send(16'd4);
    total++;
    if (valid_out !== 1'b1 || d_out !== exp) begin
      $display("FAIL avg_out got=%b/%h want=1/%h", valid_out, d_out, exp);
      bad++;
    end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL avg_idle got=%b want=0", busy); bad++;
    end
    step();
    total++;
    if (valid_out !== 1'b0 || d_out !== exp) begin
      $display("FAIL avg_drain got=%b/%h want=0/%h", valid_out, d_out, exp);
      bad++;
    end
  endtask

  task automatic test_negative();
    logic [15:0] exp;
`ifdef CONV_DECIM_ROUND_EN
    exp = 16'hFFFF;
`else
    exp = 16'hFFFE;
`endif
    decim_log2 = 3'd2;
    ready_out = 1'b1;
    send(16'hFFFF);
    send(16'hFFFF);
    send(16'hFFFF);
    send(16'hFFFE);
    total++;
    if (valid_out !== 1'b1 || d_out !== exp) begin
      $display("FAIL neg_out got=%b/%h want=1/%h", valid_out, d_out, exp);
      bad++;
    end
    step();
  endtask

  task automatic test_bounds();
    decim_log2 = 3'd4;
    ready_out = 1'b1;
    for (int i = 0; i < 16; i++) send(16'h7FFF);
    total++;
    if (valid_out !== 1'b1 || d_out !== 16'h7FFF) begin
      $display("FAIL max_out got=%b/%h want=1/7fff", valid_out, d_out);
      bad++;
    end
    for (int i = 0; i < 16; i++) send(16'h8000);
    total++;
    if (valid_out !== 1'b1 || d_out !== 16'h8000) begin
      $display("FAIL min_out got=%b/%h want=1/8000", valid_out, d_out);
      bad++;
    end
    total++;
    if (overflow !== 1'b0) begin
      $display("FAIL bnd_ovf got=%b want=0", overflow); bad++;
    end
    step();
  endtask

  task automatic test_overflow();
    decim_log2 = 3'd0;
    ready_out = 1'b0;
    send(16'd5);
    total++;
    if (valid_out !== 1'b1 || d_out !== 16'd5 || overflow !== 1'b0) begin
      $display("FAIL ovf_first got=%b/%h/%b want=1/0005/0",
               valid_out, d_out, overflow);
      bad++;
    end
    send(16'd6);
    total++;
    if (valid_out !== 1'b1 || d_out !== 16'd5 || overflow !== 1'b1) begin
      $display("FAIL ovf_drop got=%b/%h/%b want=1/0005/1",
               valid_out, d_out, overflow);
      bad++;
    end
    ready_out = 1'b1;
    step();
    total++;
    if (valid_out !== 1'b0 || d_out !== 16'd5 || overflow !== 1'b1) begin
      $display("FAIL ovf_xfer got=%b/%h/%b want=0/0005/1",
               valid_out, d_out, overflow);
      bad++;
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_clr got=%b want=0", overflow); bad++;
    end
  endtask

  task automatic test_flush();
    int pulses;
    decim_log2 = 3'd3;
    ready_out = 1'b1;
    send(16'd100);
    send(16'd200);
    valid_in = 1'b1;
    y_in = 16'd300;
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid_in = 1'b0;
    total++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin
      $display("FAIL fl_idle got=%b/%b want=0/0", busy, valid_out); bad++;
    end
    decim_log2 = 3'd1;
    send(16'd8);
    pulses = 0;
    send(16'd10);
    if (valid_out) pulses++;
    total++;
    if (valid_out !== 1'b1 || d_out !== 16'd9) begin
      $display("FAIL fl_out got=%b/%h want=1/0009", valid_out, d_out);
      bad++;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (valid_out) pulses++;
    end
    total++;
    if (pulses != 1) begin
      $display("FAIL fl_pulses got=%0d want=1", pulses); bad++;
    end
  endtask

  task automatic test_midreset();
    decim_log2 = 3'd0;
    ready_out = 1'b0;
    send(16'd7);
    decim_log2 = 3'd2;
    send(16'd1);
    send(16'd1);
    total++;
    if (busy !== 1'b1 || valid_out !== 1'b1 || d_out !== 16'd7) begin
      $display("FAIL mr_pre got=%b/%b/%h want=1/1/0007",
               busy, valid_out, d_out);
      bad++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({valid_out, overflow, busy} !== 3'b000 || d_out !== 16'h0) begin
      $display("FAIL mr_rst got=%b/%h want=000/0000",
               {valid_out, overflow, busy}, d_out);
      bad++;
    end
    ready_out = 1'b1;
    send(16'd4);
    send(16'd4);
    send(16'd4);
    total++;
    if (valid_out !== 1'b0) begin
      $display("FAIL mr_early got=%b want=0", valid_out); bad++;
    end
    send(16'd4);
    total++;
    if (valid_out !== 1'b1 || d_out !== 16'd4) begin
      $display("FAIL mr_out got=%b/%h want=1/0004", valid_out, d_out);
      bad++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_average();
    test_negative();
    test_bounds();
    test_overflow();
    test_flush();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
